// File: rtl/wb_bus_if_gen2_pkg.sv
// Shared definitions for the second-generation Wishbone bridge.
// The optional bus timeout is enabled by defining WB_IF_TIMEOUT_EN
// (left undefined by default, so the bridge waits indefinitely).
package wb_bus_if_gen2_pkg;

   // Bridge FSM encodings
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_HOLD = 2'd2
   } wb_state_e;

   // Width of the timeout counter and its limit input
   localparam int TMO_CNT_W = 16;

endpackage

// File: rtl/wb_tmo_cnt.sv
// Bus-cycle timeout counter: cleared while the bridge is not busy, counts
// each busy cycle without termination, flags expiry when it equals the limit.
module wb_tmo_cnt
   import wb_bus_if_gen2_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_clr,
   input  logic                 i_en,
   input  logic [TMO_CNT_W-1:0] i_limit,
   output logic                 o_expired
);

   logic [TMO_CNT_W-1:0] r_cnt;

   // Count unterminated busy cycles; clearing has priority over counting
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + TMO_CNT_W'(1);
      end
   end

   assign o_expired = (r_cnt == i_limit);

endmodule

// File: rtl/wb_bus_if_gen2.sv
// Pipeline memory port to Wishbone B3 classic single-beat bridge.
// One bus cycle per CPU request; stallreq holds the pipeline until the
// cycle ends, returned data/error are held while the pipeline is stalled,
// and a flush abandons the cycle. Define WB_IF_TIMEOUT_EN to terminate
// cycles that receive no ack/err within TMO_CYC busy cycles.
module wb_bus_if_gen2
   import wb_bus_if_gen2_pkg::*;
#(
   parameter  int DW      = 32,
   parameter  int AW      = 32,
   parameter  int STALL_W = 6,
   parameter  int TMO_CYC = 255,
   localparam int SW      = DW / 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall_i,
   input  logic               flush_i,
   input  logic               cpu_ce_i,
   input  logic               cpu_we_i,
   input  logic [AW-1:0]      cpu_addr_i,
   input  logic [DW-1:0]      cpu_data_i,
   input  logic [SW-1:0]      cpu_sel_i,
   output logic [DW-1:0]      cpu_data_o,
   output logic               cpu_err_o,
   output logic               stallreq,
   input  logic [DW-1:0]      wishbone_data_i,
   input  logic               wishbone_ack_i,
   input  logic               wishbone_err_i,
   output logic [AW-1:0]      wishbone_addr_o,
   output logic [DW-1:0]      wishbone_data_o,
   output logic               wishbone_we_o,
   output logic [SW-1:0]      wishbone_sel_o,
   output logic               wishbone_stb_o,
   output logic               wishbone_cyc_o
);

   wb_state_e     r_state;
   wb_state_e     w_state_next;
   logic [DW-1:0] r_rd_buf;
   logic          r_err_buf;
   logic          w_stalled;
   logic          w_accept;
   logic          w_tmo;
   logic          w_term_err;

   assign w_stalled  = |stall_i;
   assign w_accept   = (r_state == ST_IDLE) && cpu_ce_i && !flush_i;
   // A timeout ends the cycle exactly like a slave error
   assign w_term_err = wishbone_err_i | w_tmo;

`ifdef WB_IF_TIMEOUT_EN
   logic w_tmo_clr;
   logic w_tmo_en;
   logic w_tmo_expired;

   assign w_tmo_clr = (r_state != ST_BUSY);
   assign w_tmo_en  = (r_state == ST_BUSY) && !flush_i && !wishbone_err_i && !wishbone_ack_i;

   wb_tmo_cnt u_tmo_cnt (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (w_tmo_clr),
      .i_en      (w_tmo_en),
      .i_limit   (TMO_CNT_W'(TMO_CYC - 1)),
      .o_expired (w_tmo_expired)
   );

   assign w_tmo = (r_state == ST_BUSY) && w_tmo_expired;
`else
   assign w_tmo = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state and CPU-side outputs; termination priority is flush > err > ack
   always_comb begin
      w_state_next = r_state;
      cpu_data_o   = '0;
      cpu_err_o    = 1'b0;
      stallreq     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               stallreq     = 1'b1;
               w_state_next = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (flush_i) begin
               w_state_next = ST_IDLE;
            end else if (w_term_err) begin
               cpu_err_o    = 1'b1;
               w_state_next = w_stalled ? ST_HOLD : ST_IDLE;
            end else if (wishbone_ack_i) begin
               cpu_data_o   = wishbone_we_o ? '0 : wishbone_data_i;
               w_state_next = w_stalled ? ST_HOLD : ST_IDLE;
            end else begin
               stallreq = 1'b1;
            end
         end
         ST_HOLD: begin
            cpu_data_o = r_rd_buf;
            cpu_err_o  = r_err_buf;
            if (!w_stalled || flush_i) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Bus outputs and held read data / error; bus only changes at edges
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wishbone_addr_o <= '0;
         wishbone_data_o <= '0;
         wishbone_we_o   <= 1'b0;
         wishbone_sel_o  <= '0;
         wishbone_stb_o  <= 1'b0;
         wishbone_cyc_o  <= 1'b0;
         r_rd_buf        <= '0;
         r_err_buf       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  wishbone_addr_o <= cpu_addr_i;
                  wishbone_data_o <= cpu_data_i;
                  wishbone_we_o   <= cpu_we_i;
                  wishbone_sel_o  <= cpu_sel_i;
                  wishbone_stb_o  <= 1'b1;
                  wishbone_cyc_o  <= 1'b1;
               end
            end
            ST_BUSY: begin
               if (flush_i) begin
                  wishbone_stb_o <= 1'b0;
                  wishbone_cyc_o <= 1'b0;
               end else if (w_term_err) begin
                  wishbone_stb_o <= 1'b0;
                  wishbone_cyc_o <= 1'b0;
                  r_err_buf      <= 1'b1;
                  r_rd_buf       <= '0;
               end else if (wishbone_ack_i) begin
                  wishbone_stb_o <= 1'b0;
                  wishbone_cyc_o <= 1'b0;
                  r_err_buf      <= 1'b0;
                  r_rd_buf       <= wishbone_we_o ? '0 : wishbone_data_i;
               end
            end
            ST_HOLD: begin
               if (!w_stalled || flush_i) begin
                  r_err_buf <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/wb_bus_if_gen2.md
Name: wb_bus_if_gen2

Overview:
Parametrised second-generation bridge between a pipeline-side memory port (instruction fetch or data MEM stage) and a Wishbone B3 classic master port. It issues one single-beat cycle per CPU request and asserts stallreq until the cycle terminates. It holds returned read data while the pipeline is stalled for other reasons, and abandons the cycle on flush. Unlike the first generation, it has configurable widths, handles the bus-error input (err_i), and reports an error to the CPU.

Parameters:
DW, 32, data width in bits; multiple of 8
AW, 32, address width in bits
SW, DW/8, byte-select width (derived, not overridable)
STALL_W, 6, width of the pipeline stall vector
TMO_CYC, 255, bus cycles allowed before timeout (used only with the optional feature); range 1..65535

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
stall_i  in  STALL_W  pipeline stall vector; any bit set = pipeline frozen
flush_i  in  1  pipeline flush (exception)
cpu_ce_i  in  1  CPU request valid
cpu_we_i  in  1  1 = write
cpu_addr_i  in  AW  request address
cpu_data_i  in  DW  write data
cpu_sel_i  in  SW  byte enables
cpu_data_o  out  DW  read data to pipeline
cpu_err_o  out  1  access terminated by error or timeout
stallreq  out  1  stall request to ctrl
wishbone_data_i  in  DW  bus read data
wishbone_ack_i  in  1  bus acknowledge
wishbone_err_i  in  1  bus error termination
wishbone_addr_o  out  AW  bus address
wishbone_data_o  out  DW  bus write data
wishbone_we_o  out  1  bus write enable
wishbone_sel_o  out  SW  bus byte select
wishbone_stb_o  out  1  strobe
wishbone_cyc_o  out  1  cycle valid

Behaviour:
- FSM has three states: IDLE, BUSY, HOLD. Reset (rst=0, asynchronous) forces IDLE and clears these to 0: all wishbone_*_o, rd_buf, err_buf and the timeout counter. With the FSM in IDLE, cpu_data_o=0, cpu_err_o=0 and stallreq=0.
- IDLE: if cpu_ce_i=1 and flush_i=0, then:
  - on the next edge, register addr/data/we/sel onto the bus outputs, set stb=cyc=1 and go to BUSY;
  - in the same cycle, stallreq=1 combinationally.
- BUSY, termination priority is flush_i > err > ack:
  - flush_i=1: drop stb/cyc, go to IDLE, stallreq=0, discard any ack/err in that cycle.
  - wishbone_err_i=1 (wins over a simultaneous ack): drop stb/cyc, set err_buf=1, rd_buf=0. Same cycle: cpu_err_o=1, cpu_data_o=0, stallreq=0. Next state is HOLD if stall_i!=0, else IDLE.
  - wishbone_ack_i=1: drop stb/cyc, capture rd_buf=wishbone_data_i (writes capture 0). Same cycle: cpu_data_o=wishbone_data_i for reads (0 for writes), stallreq=0. Next state is HOLD if stall_i!=0, else IDLE.
  - No termination: stallreq=1, cpu_data_o=0, bus outputs held stable.
- HOLD: cpu_data_o=rd_buf, cpu_err_o=err_buf, stallreq=0.
  - Leave to IDLE when stall_i==0 or flush_i=1; clear err_buf on exit.
  - No new request is accepted in HOLD.
- Latency: minimum two cycles from request to data (issue edge, then ack cycle). A zero-wait slave acking in the first BUSY cycle meets this.
- Bus outputs change only at clock edges; stb and cyc are always equal.
- cpu_data_o, cpu_err_o and stallreq are combinational from state plus bus inputs.
- Back-to-back requests: an IDLE cycle always separates consecutive cycles.
- Reset mid-cycle: the bus is released immediately (asynchronous); the slave must tolerate cyc falling without termination.

Optional Feature:
Macro WB_IF_TIMEOUT_EN.
- Defined: a 16-bit counter clears on entering BUSY and increments each BUSY cycle without termination. When it reaches TMO_CYC-1 with no ack/err/flush, the cycle terminates exactly as for wishbone_err_i.
- Not defined: the counter and compare logic are absent, and BUSY waits indefinitely.

Decomposition:
- Shared package/defines: FSM state encodings (2-bit, IDLE=0, BUSY=1, HOLD=2) and the WB_IF_TIMEOUT_EN default (undefined).
- The timeout counter is the one natural sub-module: wb_tmo_cnt (clear, enable, limit in; expired out). It is instantiated only under the macro.
- Both openmips instances (instruction and data) are replaced by this block. The instruction side ties cpu_we_i=0 and cpu_sel_i to all ones.

Test Plan:
- Read, ack after 3 wait cycles, stall_i=0: stallreq high for 4 cycles; in the ack cycle cpu_data_o=32'hDEADBEEF; IDLE next.
- Read, ack while stall_i=6'b000011: state enters HOLD; cpu_data_o stays 32'hDEADBEEF until stall_i=0; returns to IDLE on the next edge.
- Write to addr 32'h0000_0100 with sel=4'b0011: bus outputs match for the whole cycle; we_o=1; cpu_data_o=0 at ack.
- flush_i in the second BUSY cycle, with ack in the same cycle: stb/cyc drop next edge; stallreq=0; cpu_data_o=0; cpu_err_o=0.
- err_i and ack_i asserted together: cpu_err_o=1, cpu_data_o=0. With WB_IF_TIMEOUT_EN and TMO_CYC=8 and no ack: cpu_err_o=1 after 8 BUSY cycles.
- rst pulled low mid-BUSY: cyc_o/stb_o=0 immediately; after release the state is IDLE and all outputs are 0.
